// File: rtl/tpu_tiled_engine.sv
// tpu_tiled_engine: tiled GEMM C = A x B on an SA_DIM x SA_DIM output-stationary systolic array.
// Optional macro TPU_SIGNED_EN: A/B elements are two's complement (default unsigned).
module tpu_tiled_engine #(
  parameter int SA_DIM    = 4,
  parameter int ELEM_BITS = 8,
  parameter int ACC_BITS  = 32,
  parameter int ADDR_BITS = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  input  logic [7:0]                  K,
  input  logic [7:0]                  M,
  input  logic [7:0]                  N,
  output logic                        busy,
  output logic                        ap_done,
  output logic                        ap_idle,
  output logic                        A_wr_en,
  output logic [ADDR_BITS-1:0]        A_index,
  input  logic [SA_DIM*ELEM_BITS-1:0] A_data_out,
  output logic                        B_wr_en,
  output logic [ADDR_BITS-1:0]        B_index,
  input  logic [SA_DIM*ELEM_BITS-1:0] B_data_out,
  output logic                        C_wr_en,
  output logic [ADDR_BITS-1:0]        C_index,
  output logic [SA_DIM*ACC_BITS-1:0]  C_data_in
);
  localparam int EW = ELEM_BITS;
  localparam int AW = ACC_BITS;
  localparam int PW = 2 * ELEM_BITS;
  localparam int IW = $clog2(SA_DIM);
  typedef enum logic [2:0] {IDLE, FEED, FLUSH, WRITE, DONE} state_t;
  state_t        state_q;
  logic [7:0]    k_q, m_q, n_q, mt_q, nt_q, cnt_q;
  logic          busy_q, done_q, idle_q, vld_q;
  logic [EW-1:0] a_m [SA_DIM];
  logic [EW-1:0] b_m [SA_DIM];
  logic [EW-1:0] a_e [SA_DIM];
  logic [EW-1:0] b_e [SA_DIM];
  logic [EW-1:0] a_q [SA_DIM][SA_DIM-1];
  logic [EW-1:0] b_q [SA_DIM-1][SA_DIM];
  logic [AW-1:0] acc_q [SA_DIM][SA_DIM];
  logic [15:0]   row_base, col_base, row;
  logic [8:0]    nt_tot;
  logic          last_mt, last_nt, feed, wr, clr;
  logic [IW-1:0] wsel;

  assign feed     = state_q == FEED;
  assign wr       = state_q == WRITE;
  assign clr      = feed && cnt_q == 8'd0;
  assign wsel     = cnt_q[IW-1:0];
  assign row_base = 16'(mt_q) * 16'(SA_DIM);
  assign col_base = 16'(nt_q) * 16'(SA_DIM);
  assign row      = row_base + 16'(cnt_q);
  assign nt_tot   = 9'((16'(n_q) + 16'(SA_DIM - 1)) / 16'(SA_DIM));
  assign last_mt  = row_base + 16'(SA_DIM) >= 16'(m_q);
  assign last_nt  = col_base + 16'(SA_DIM) >= 16'(n_q);

  assign busy    = busy_q;
  assign ap_done = done_q;
  assign ap_idle = idle_q;
  assign A_wr_en = 1'b0;
  assign B_wr_en = 1'b0;
  assign A_index = feed ? ADDR_BITS'(32'(mt_q) * 32'(k_q) + 32'(cnt_q)) : '0;
  assign B_index = feed ? ADDR_BITS'(32'(nt_q) * 32'(k_q) + 32'(cnt_q)) : '0;
  assign C_wr_en = wr && row < 16'(m_q);
  assign C_index = wr ? ADDR_BITS'(32'(row) * 32'(nt_tot) + 32'(nt_q)) : '0;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      {k_q, m_q, n_q, mt_q, nt_q, cnt_q} <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      idle_q  <= 1'b1;
      vld_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      vld_q  <= feed;
      case (state_q)
        IDLE: if (in_valid) begin
          {k_q, m_q, n_q} <= {K, M, N};
          {mt_q, nt_q, cnt_q} <= '0;
          busy_q <= 1'b1;
          idle_q <= 1'b0;
          state_q <= (K == 8'd0 || M == 8'd0 || N == 8'd0) ? DONE : FEED;
          done_q <= K == 8'd0 || M == 8'd0 || N == 8'd0;
        end
        FEED: begin
          cnt_q <= (cnt_q == k_q - 8'd1) ? 8'd0 : cnt_q + 8'd1;
          if (cnt_q == k_q - 8'd1) state_q <= FLUSH;
        end
        FLUSH: begin
          cnt_q <= (cnt_q == 8'(2 * SA_DIM - 1)) ? 8'd0 : cnt_q + 8'd1;
          if (cnt_q == 8'(2 * SA_DIM - 1)) state_q <= WRITE;
        end
        WRITE: if (cnt_q == 8'(SA_DIM - 1)) begin
          cnt_q   <= 8'd0;
          nt_q    <= last_nt ? 8'd0 : nt_q + 8'd1;
          mt_q    <= (last_nt && !last_mt) ? mt_q + 8'd1 : mt_q;
          state_q <= (last_nt && last_mt) ? DONE : FEED;
          done_q  <= last_nt && last_mt;
        end else begin
          cnt_q <= cnt_q + 8'd1;
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
          idle_q  <= 1'b1;
        end
        default: state_q <= IDLE;
      endcase
    end

  // Lanes beyond the matrix edge enter as zero; vld_q marks the cycle buffer data returns.
  always_comb
    for (int i = 0; i < SA_DIM; i++) begin
      a_m[i] = (vld_q && row_base + 16'(i) < 16'(m_q)) ? A_data_out[i*EW +: EW] : '0;
      b_m[i] = (vld_q && col_base + 16'(i) < 16'(n_q)) ? B_data_out[i*EW +: EW] : '0;
    end

  always_comb
    for (int j = 0; j < SA_DIM; j++)
      C_data_in[j*AW +: AW] = (wr && col_base + 16'(j) < 16'(n_q)) ? acc_q[wsel][j] : '0;

  for (genvar i = 0; i < SA_DIM; i++) begin : g_skew
    if (i == 0) begin : g_d0
      assign a_e[i] = a_m[i];
      assign b_e[i] = b_m[i];
    end else begin : g_dn
      logic [i*EW-1:0] as_q, bs_q;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          as_q <= '0;
          bs_q <= '0;
        end else begin
          as_q <= (as_q << EW) | (i*EW)'(a_m[i]);
          bs_q <= (bs_q << EW) | (i*EW)'(b_m[i]);
        end
      assign a_e[i] = as_q[i*EW-1 -: EW];
      assign b_e[i] = bs_q[i*EW-1 -: EW];
    end
  end

  for (genvar i = 0; i < SA_DIM; i++) begin : g_row
    for (genvar j = 0; j < SA_DIM; j++) begin : g_col
      logic [EW-1:0] ai, bi;
      logic [AW-1:0] pe;
      if (j == 0) begin : g_al
        assign ai = a_e[i];
      end else begin : g_ai
        assign ai = a_q[i][j-1];
      end
      if (i == 0) begin : g_bt
        assign bi = b_e[j];
      end else begin : g_bi
        assign bi = b_q[i-1][j];
      end
`ifdef TPU_SIGNED_EN
      logic signed [PW-1:0] p;
      assign p = $signed(ai) * $signed(bi);
`else
      logic [PW-1:0] p;
      assign p = ai * bi;
`endif
      assign pe = AW'(p);
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) acc_q[i][j] <= '0;
        else acc_q[i][j] <= clr ? '0 : acc_q[i][j] + pe;
      if (j < SA_DIM - 1) begin : g_ap
        always_ff @(posedge clk or negedge rst_n)
          if (!rst_n) a_q[i][j] <= '0;
          else a_q[i][j] <= ai;
      end
      if (i < SA_DIM - 1) begin : g_bp
        always_ff @(posedge clk or negedge rst_n)
          if (!rst_n) b_q[i][j] <= '0;
          else b_q[i][j] <= bi;
      end
    end
  end
endmodule
